router_input_buffer: RTL
========================

// Module: router_input_buffer
// PURPOSE
//  Per-input-port packet buffer of the router; sits directly upstream of round_robin_arbiter.
//  Queues incoming flits, decodes the head flit's 2-bit destination port, presents a one-hot
//  request to the output arbiters and pops the head when the matching grant returns.
//  One instance per input port; the four req outputs of one port feed the req0..req3 arbiter inputs.
// PARAMETERS
//  DATA_WIDTH  64  flit width in bits; bits [DATA_WIDTH-1:DATA_WIDTH-2] hold the destination port index
//  DEPTH       4   FIFO entries; power of two, >= 2
//  PORT_ID     0   index of this input port (0..3); used only by the loopback check
// PORTS
//  clk        in   1           single clock, all state on rising edge
//  rst_n      in   1           asynchronous, active-high reset (asserted = 1 clears all state)
//  in_valid   in   1           upstream flit valid
//  in_ready   out  1           buffer can accept a flit this cycle
//  in_data    in   DATA_WIDTH  upstream flit
//  req        out  4           one-hot request for head flit's output port (4'b0001=port0 .. 4'b1000=port3)
//  grant      in   4           one-hot grant from the arbiter(s) serving this port
//  out_data   out  DATA_WIDTH  head flit, valid whenever req != 0
//  occupancy  out  log2(DEPTH)+1  number of stored flits
//  err        out  1           sticky: grant mismatch or loopback flit seen
// BEHAVIOUR
//  Clocking and reset: one clock; reset is asynchronous and active-high.
//  - Reset values: req=0, out_data=0, occupancy=0, in_ready=1, err=0; pointers cleared, storage contents don't-care.
//  - Reset mid-operation flushes all stored flits immediately; no flit is emitted after reset.
//  Push: in_valid && in_ready at a rising edge writes in_data at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
//  - in_ready = (occupancy < DEPTH); combinational from registered count only, never from grant.
//  - in_valid while full is ignored (no write, no pointer move); upstream must hold the flit.
//  Request: req = empty ? 4'b0000 : (4'b0001 << head[DATA_WIDTH-1 -: 2]).
//  - req and out_data change only on a clock edge (derived from registered head/count); zero-latency
//    from push to req when buffer was empty: flit written at edge N shows on req after edge N.
//  Pop: pop = (grant == req) && (req != 0), sampled at the rising edge; rd_ptr advances, wraps.
//  - grant != 0 and grant != req: no pop, err set (sticky until reset).
//  - grant == 0: head held, req held steady (arbiter must see a stable request).
//  Simultaneous push and pop: both happen; occupancy unchanged; legal at any fill level except push
//    when full (in_ready=0 that cycle, so push is refused even though a pop frees a slot).
//  Empty + push: flit appears as head next cycle; no bypass path in the same cycle.
//  Loopback: head destination == PORT_ID sets err but is still requested/forwarded normally.
//  Widths: occupancy is log2(DEPTH)+1 bits so full (=DEPTH) is distinct from empty; pointers log2(DEPTH).
//  FSM (per port, derived from occupancy): EMPTY (count 0) -> ACTIVE (0<count<DEPTH) -> FULL (count=DEPTH);
//    EMPTY->ACTIVE on push, ACTIVE->FULL on push-without-pop at DEPTH-1, FULL->ACTIVE on pop,
//    ACTIVE->EMPTY on pop-without-push at count 1; DEPTH=2 edge: EMPTY<->ACTIVE<->FULL still hold.
// STRUCTURE
//  Shared package router_pkg: PORT_NUM=4, PORT_SEL_W=2, one-hot constants REQ_PORT0..REQ_PORT3
//    (4'b0001/0010/0100/1000, shared with the arbiter), dest-field position macro/function.
//  Sub-module sync_fifo (DATA_WIDTH, DEPTH): storage, pointers, count, full/empty; this block adds
//    route decode, grant check, err flag and the req/out_data outputs.
// TESTING
//  1 Reset: hold rst_n=1 mid-stream with 3 flits queued -> req=0, occupancy=0, in_ready=1, err=0 same cycle (async).
//  2 Single flit: push flit with dest bits 2'b10, grant=0 for 3 cycles -> req=4'b0100 held, out_data=flit;
//    grant=4'b0100 -> next cycle req=0, occupancy=0.
//  3 Fill/wrap: DEPTH=4, push 4 flits dest 0,1,2,3 -> in_ready=0, 5th push ignored; pop all with matching
//    grants -> req sequence 0001,0010,0100,1000; push 4 more -> order preserved across pointer wrap.
//  4 Simultaneous: occupancy=2, push and matching grant same edge -> occupancy stays 2, next head correct;
//    occupancy=4 with push+grant -> pop only, occupancy=3.
//  5 Grant mismatch: head dest 1 (req=0010), grant=4'b0100 -> no pop, occupancy unchanged, err=1 and stays 1.
//  6 Loopback: PORT_ID=2, push flit dest 2 -> err=1, req=4'b0100 still asserted and popped on grant.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions.
// Holds port count, destination-field width, the one-hot request codes shared
// with round_robin_arbiter, the buffer occupancy-state enum and small helpers
// for locating and decoding the destination field of a flit.
package router_pkg;

  localparam int PORT_NUM   = 4;
  localparam int PORT_SEL_W = 2;

  typedef logic [PORT_NUM-1:0]   req_t;
  typedef logic [PORT_SEL_W-1:0] port_sel_t;

  localparam req_t REQ_PORT0 = 4'b0001;
  localparam req_t REQ_PORT1 = 4'b0010;
  localparam req_t REQ_PORT2 = 4'b0100;
  localparam req_t REQ_PORT3 = 4'b1000;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACTIVE,
    ST_FULL
  } buf_state_e;

  // The destination port index occupies the top PORT_SEL_W bits of a flit.
  function automatic int dest_lsb(input int data_width);
    return data_width - PORT_SEL_W;
  endfunction

  function automatic req_t port_onehot(input port_sel_t sel);
    case (sel)
      2'd0:    return REQ_PORT0;
      2'd1:    return REQ_PORT1;
      2'd2:    return REQ_PORT2;
      default: return REQ_PORT3;
    endcase
  endfunction

endpackage

// File: rtl/router_input_buffer_if.sv
// Handshake bundle of one router input buffer.
//   in_valid / in_ready / in_data : upstream flit handshake
//   req / grant                   : one-hot request to and grant from the arbiters
//   out_data                      : head flit forwarded downstream
// Modports: slave = the buffer, master = whatever drives it (upstream + arbiters).
interface router_input_buffer_if #(
  parameter int DATA_WIDTH = 64
);
  import router_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  req_t                  req;
  req_t                  grant;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, grant,
    input  in_ready, req, out_data
  );

  modport slave (
    input  in_valid, in_data, grant,
    output in_ready, req, out_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage, read/write pointers and occupancy count.
// Ports:
//   clk, rst_n   clock; asynchronous reset, active-high despite its name
//   push_i       write wr_data_i (ignored when full)
//   pop_i        drop the head entry (ignored when empty)
//   wr_data_i    data to store
//   rd_data_o    head entry (meaningful only when not empty)
//   count_o      number of stored entries, 0..DEPTH
//   empty_o      count_o == 0
module sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 by overflow.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; count/pointers gate its use, so contents after reset don't matter.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/router_input_buffer.sv
// Per-input-port flit buffer of the router, upstream of round_robin_arbiter.
// Queues flits, decodes the head flit's destination into a one-hot request,
// pops the head when the matching grant returns, and flags protocol errors.
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous reset, ACTIVE-HIGH (1 clears all state)
//   bus        router_input_buffer_if.slave: in_valid/in_ready/in_data,
//              req/grant, out_data
//   occupancy  number of stored flits, 0..DEPTH
//   err        sticky: grant mismatch or loopback head flit seen
module router_input_buffer
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int PORT_ID    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  router_input_buffer_if.slave   bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   err
);

  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int DEST_LSB = dest_lsb(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] head;
  logic [CNT_W-1:0]      count;
  logic                  empty;
  port_sel_t             head_dest;
  req_t                  req;
  logic                  push;
  logic                  pop;
  logic                  grant_mismatch;
  logic                  loopback;

  buf_state_e            state_q;
  buf_state_e            state_d;
  logic                  in_ready_q;
  logic                  err_q;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .pop_i     (pop),
    .wr_data_i (bus.in_data),
    .rd_data_o (head),
    .count_o   (count),
    .empty_o   (empty)
  );

  // req/out_data depend only on registered FIFO state, so they move on clock edges only.
  assign head_dest = head[DEST_LSB +: PORT_SEL_W];
  assign req       = empty ? '0 : port_onehot(head_dest);

  // in_ready is a registered FSM output and never looks at grant, so a pop
  // cannot reopen a full buffer in the same cycle.
  assign push = bus.in_valid && in_ready_q;
  assign pop  = (bus.grant == req) && (req != '0);

  assign grant_mismatch = (bus.grant != '0) && (bus.grant != req);
  assign loopback       = !empty && (head_dest == port_sel_t'(PORT_ID));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (push && !pop && count == CNT_W'(DEPTH - 1)) begin
          state_d = ST_FULL;
        end else if (pop && !push && count == CNT_W'(1)) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) state_d = ST_ACTIVE;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      err_q      <= err_q | grant_mismatch | loopback;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.req      = req;
  assign bus.out_data = empty ? '0 : head;
  assign occupancy    = count;
  assign err          = err_q;

endmodule
